// File: rtl/avst_pkg.sv
// rtl/avst_pkg.sv - shared constants and output FSM state type for the packet buffer
package avst_pkg;

  localparam int AVST_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    FLUSH = 2'd2
  } out_state_t;

endpackage

// File: rtl/avst_sync_fifo.sv
// rtl/avst_sync_fifo.sv - single-clock FIFO with full/empty flags and occupancy count
module avst_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_fire;
  logic             rd_fire;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage is intentionally left out of reset; only pointers and count matter.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/avst_pkt_buffer.sv
// rtl/avst_pkt_buffer.sv - store-and-forward packet FIFO with oversize-packet flush
module avst_pkt_buffer
  import avst_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [AVST_DATA_W-1:0] data_in,
  input  logic                   end_in,
  input  logic                   valid_in,
  output logic                   ready_in,
  output logic [AVST_DATA_W-1:0] data_out,
  output logic                   end_out,
  output logic                   valid_out,
  input  logic                   ready_out
);

  localparam int AW = $clog2(DEPTH);

  logic [AVST_DATA_W:0] rd_word;
  logic                 full;
  logic                 empty;
  logic [AW:0]          occ;
  logic [AW:0]          pkt_count;
  logic [AW:0]          pkt_count_next;
  out_state_t           state;
  logic                 in_fire;
  logic                 out_fire;
  logic                 in_end;
  logic                 out_end;

  avst_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (AVST_DATA_W + 1)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (in_fire),
    .wr_data ({end_in, data_in}),
    .rd_en   (out_fire),
    .rd_data (rd_word),
    .full    (full),
    .empty   (empty),
    .count   (occ)
  );

  assign ready_in  = !reset && (occ < (AW+1)'(DEPTH));
  assign valid_out = !reset && (state != IDLE) && !empty;
  assign data_out  = valid_out ? rd_word[AVST_DATA_W-1:0] : '0;
  assign end_out   = valid_out && rd_word[AVST_DATA_W];

  assign in_fire  = valid_in && ready_in;
  assign out_fire = valid_out && ready_out;
  assign in_end   = in_fire && end_in;
  assign out_end  = out_fire && rd_word[AVST_DATA_W];

  always_comb begin
    pkt_count_next = pkt_count;
    if (in_end && !out_end) begin
      pkt_count_next = pkt_count + (AW+1)'(1);
    end else if (out_end && !in_end) begin
      pkt_count_next = pkt_count - (AW+1)'(1);
    end
  end

  // Counting the end beat landing on this edge lets the first byte appear one cycle sooner.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pkt_count <= '0;
    end else begin
      pkt_count <= pkt_count_next;
      case (state)
        IDLE: begin
          if (pkt_count_next != '0) begin
            state <= SEND;
          end else if (full && pkt_count == '0) begin
            state <= FLUSH;
          end
        end
        SEND: begin
          if (out_end && pkt_count_next == '0) begin
            state <= IDLE;
          end
        end
        FLUSH: begin
          if (out_end) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avst_pkt_buffer.sv
// tb/tb_avst_pkt_buffer.sv - scoreboard bench for avst_pkt_buffer
module tb_avst_pkt_buffer;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       end_in;
  logic       valid_in;
  logic       ready_in;
  logic [7:0] data_out;
  logic       end_out;
  logic       valid_out;
  logic       ready_out;

  int         tests = 0;
  int         fails = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_word;
  int         mdl_occ = 0;
  int         mdl_ends = 0;
  bit         flushing = 0;
  bit         hold_pending = 0;
  logic [8:0] hold_word;
  bit         rand_ready = 0;

  always #5 clk = ~clk;

  avst_pkt_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .end_in    (end_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .end_out   (end_out),
    .valid_out (valid_out),
    .ready_out (ready_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: abstract model is a byte queue plus counts of stored bytes and stored end markers.
  always @(negedge clk) begin
    if (reset) begin
      check("reset_ready_in", ready_in, 0);
      check("reset_valid_out", valid_out, 0);
      check("reset_data_out", data_out, 0);
      check("reset_end_out", end_out, 0);
      mdl_occ      = 0;
      mdl_ends     = 0;
      flushing     = 0;
      hold_pending = 0;
    end else begin
      check("ready_in_vs_occupancy", ready_in, (mdl_occ < DEPTH));
      if (valid_out) begin
        check("valid_with_data", (mdl_occ > 0), 1);
        check("store_and_forward", (mdl_ends > 0) || flushing, 1);
      end
      if (hold_pending) begin
        check("stall_valid_held", valid_out, 1);
        check("stall_word_held", {end_out, data_out}, hold_word);
      end
      hold_pending = valid_out && !ready_out;
      hold_word    = {end_out, data_out};
      if (valid_out && ready_out) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL scoreboard_underflow: got 0x%0h expected nothing", {end_out, data_out});
        end else begin
          mon_word = exp_q.pop_front();
          if ({end_out, data_out} !== mon_word) begin
            fails++;
            $display("FAIL out_word: got 0x%0h expected 0x%0h at %0t", {end_out, data_out}, mon_word, $time);
          end
        end
        mdl_occ--;
        if (end_out) begin
          mdl_ends--;
          flushing = 0;
        end
      end
      if (valid_in && ready_in) begin
        mdl_occ++;
        if (end_in) mdl_ends++;
      end
      if (mdl_occ == DEPTH && mdl_ends == 0) flushing = 1;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      ready_out = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic e);
    bit accepted = 0;
    valid_in = 1'b1;
    data_in  = d;
    end_in   = e;
    for (int i = 0; i < 4000 && !accepted; i++) begin
      @(negedge clk);
      if (ready_in) begin
        exp_q.push_back({e, d});
        accepted = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      tests++;
      fails++;
      $display("FAIL in_accept_timeout: byte 0x%0h not accepted", d);
    end
    valid_in = 1'b0;
    data_in  = '0;
    end_in   = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !valid_out) done = 1;
    end
    check("drain_done", done, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [8:0] w);
    @(negedge clk);
    check({name, "_valid"}, valid_out, 1);
    check({name, "_word"}, {end_out, data_out}, w);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         found;
    int         len;
    logic [8:0] stall_word;

    reset     = 1'b1;
    valid_in  = 1'b0;
    data_in   = '0;
    end_in    = 1'b0;
    ready_out = 1'b0;
    idle_cycles(3);
    reset = 1'b0;

    // Basic packet with latency and back-to-back output.
    ready_out = 1'b1;
    @(negedge clk);
    check("ready_after_reset", ready_in, 1);
    @(posedge clk);
    #1;
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b0);
    send_beat(8'h03, 1'b1);
    expect_out("s1_b0", 9'h001);
    expect_out("s1_b1", 9'h002);
    expect_out("s1_b2", 9'h103);
    @(negedge clk);
    check("s1_idle_after", valid_out, 0);
    @(posedge clk);
    #1;

    // Two queued packets leave back-to-back.
    ready_out = 1'b0;
    send_beat(8'h10, 1'b0);
    send_beat(8'h11, 1'b1);
    send_beat(8'h20, 1'b1);
    idle_cycles(2);
    ready_out = 1'b1;
    expect_out("s2_b0", 9'h010);
    expect_out("s2_b1", 9'h111);
    expect_out("s2_b2", 9'h120);
    @(negedge clk);
    check("s2_idle_after", valid_out, 0);
    @(posedge clk);
    #1;

    // Oversize packet fills the buffer and is flushed.
    ready_out = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_beat(8'h30 + 8'(i), 1'b0);
    @(negedge clk);
    check("s3_full_ready_in", ready_in, 0);
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      if (valid_out) found = 1;
      else @(negedge clk);
    end
    check("s3_flush_valid", found, 1);
    @(posedge clk);
    #1;
    ready_out = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    ready_out = 1'b0;
    @(negedge clk);
    check("s3_ready_after_read", ready_in, 1);
    @(posedge clk);
    #1;
    ready_out = 1'b1;
    send_beat(8'h4F, 1'b1);
    wait_drain();

    // Downstream stall mid-packet.
    ready_out = 1'b0;
    send_beat(8'h50, 1'b0);
    send_beat(8'h51, 1'b0);
    send_beat(8'h52, 1'b0);
    send_beat(8'h53, 1'b1);
    ready_out = 1'b1;
    expect_out("s4_b0", 9'h050);
    @(posedge clk);
    #1;
    ready_out = 1'b0;
    @(negedge clk);
    stall_word = {end_out, data_out};
    check("s4_stall_first", stall_word, 9'h051);
    idle_cycles(4);
    @(negedge clk);
    check("s4_stall_valid", valid_out, 1);
    check("s4_stall_word", {end_out, data_out}, stall_word);
    @(posedge clk);
    #1;
    ready_out = 1'b1;
    wait_drain();

    // Reset mid-packet discards the partial packet.
    ready_out = 1'b0;
    send_beat(8'hA0, 1'b0);
    send_beat(8'hA1, 1'b0);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("s5_reset_valid", valid_out, 0);
    check("s5_reset_ready", ready_in, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("s5_ready_after_reset", ready_in, 1);
    @(posedge clk);
    #1;
    ready_out = 1'b1;
    send_beat(8'hAA, 1'b1);
    expect_out("s5_only", 9'h1AA);
    @(negedge clk);
    check("s5_idle_after", valid_out, 0);
    @(posedge clk);
    #1;

    // Random traffic, with occasional oversize packets.
    rand_ready = 1;
    for (int p = 0; p < 1000; p++) begin
      len = ($urandom_range(0, 19) == 0) ? $urandom_range(17, 24) : $urandom_range(1, 8);
      for (int b = 0; b < len; b++) begin
        idle_cycles($urandom_range(0, 1));
        send_beat(8'($urandom_range(0, 255)), (b == len - 1));
      end
    end
    rand_ready = 0;
    idle_cycles(1);
    ready_out = 1'b1;
    wait_drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
